ysyx_22040895_ifu: RTL

//  Instruction fetch stage; sits directly upstream of the decode stage.

---
 rtl/ysyx_22040895_ifu_pkg.sv | 26 ++
 rtl/ysyx_22040895_ifu_pcgen.sv | 40 ++++
 rtl/ysyx_22040895_ifu.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared definitions for the ysyx_22040895 instruction fetch unit.
// Bus widths, FSM state encodings, reset PC and the NOP filler instruction.
package ysyx_22040895_ifu_pkg;

  localparam int INST_BUS_W = 32;
  localparam int INST_ADDR_BUS_W = 64;

  localparam logic [INST_ADDR_BUS_W-1:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INST_BUS_W-1:0]      IFU_NOP_INST = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;

  function automatic inst_addr_t align_pc(input inst_addr_t addr);
    return addr & ~inst_addr_t'(3);
  endfunction

  function automatic logic is_misaligned(input inst_addr_t addr);
    return |(addr & inst_addr_t'(3));
  endfunction

endpackage

// File: rtl/ysyx_22040895_ifu_pcgen.sv
// PC register for the fetch unit: reset load, +4 advance, redirect mux and alignment.
// YSYX_22040895_IFU_MISALIGN_CHK_EN keeps misaligned targets and flags them instead of masking.
module ysyx_22040895_ifu_pcgen
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter logic [INST_ADDR_BUS_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_BUS_W-1:0] redirect_pc,
  input  logic                       advance,
  output logic [INST_ADDR_BUS_W-1:0] pc
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
  ,
  output logic                       misaligned
`endif
);

  logic [INST_ADDR_BUS_W-1:0] target;

`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
  assign target     = redirect_pc;
  assign misaligned = redirect_valid && is_misaligned(redirect_pc);
`else
  assign target = align_pc(redirect_pc);
`endif

  // Redirect always wins over the sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + 64'd4;
    end
  end

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch stage: blocking single-outstanding fetch with redirect and one held instruction.
// YSYX_22040895_IFU_MISALIGN_CHK_EN adds excp_o_ifu for misaligned redirect targets.
module ysyx_22040895_ifu
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter logic [INST_ADDR_BUS_W-1:0] RESET_PC = IFU_RESET_PC,
  parameter logic [INST_BUS_W-1:0]      NOP_INST = IFU_NOP_INST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid_i_ifu,
  input  logic [INST_ADDR_BUS_W-1:0] redirect_pc_i_ifu,
  output logic                       imem_req_valid_o_ifu,
  input  logic                       imem_req_ready_i_ifu,
  output logic [INST_ADDR_BUS_W-1:0] imem_addr_o_ifu,
  input  logic                       imem_rsp_valid_i_ifu,
  input  logic [INST_BUS_W-1:0]      imem_rsp_data_i_ifu,
  output logic                       inst_valid_o_ifu,
  input  logic                       inst_ready_i_ifu,
  output logic [INST_BUS_W-1:0]      inst_o_ifu,
  output logic [INST_ADDR_BUS_W-1:0] pc_o_ifu
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
  ,
  output logic                       excp_o_ifu
`endif
);

  logic [1:0]                 state;
  logic [1:0]                 state_next;
  logic                       drop;
  logic                       abandon;
  logic                       advance;
  logic                       redirect_bad;
  logic [INST_BUS_W-1:0]      inst_reg;
  logic [INST_ADDR_BUS_W-1:0] pc;

  assign advance = (state == S_HOLD) && inst_ready_i_ifu && !redirect_valid_i_ifu;

  ysyx_22040895_ifu_pcgen #(.RESET_PC(RESET_PC)) u_pcgen (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid_i_ifu),
    .redirect_pc    (redirect_pc_i_ifu),
    .advance        (advance),
    .pc             (pc)
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
    ,
    .misaligned     (redirect_bad)
`endif
  );

`ifndef YSYX_22040895_IFU_MISALIGN_CHK_EN
  assign redirect_bad = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ:  if (imem_req_ready_i_ifu) state_next = S_WAIT;
      S_WAIT: if (imem_rsp_valid_i_ifu) state_next = drop ? S_REQ : S_HOLD;
      S_HOLD: if (inst_ready_i_ifu) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
    // An accepted request must still be waited out, so REQ+accept goes to WAIT even on redirect.
    if (redirect_valid_i_ifu) begin
      if (redirect_bad) begin
        state_next = S_HOLD;
      end else begin
        case (state)
          S_REQ:   state_next = imem_req_ready_i_ifu ? S_WAIT : S_REQ;
          S_WAIT:  state_next = imem_rsp_valid_i_ifu ? S_REQ : S_WAIT;
          default: state_next = S_REQ;
        endcase
      end
    end
  end

  // drop marks a wrong-path request still in flight; its response clears it wherever it lands.
  assign abandon = redirect_valid_i_ifu &&
                   (((state == S_REQ) && imem_req_ready_i_ifu) ||
                    ((state == S_WAIT) && !imem_rsp_valid_i_ifu));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      if (abandon) begin
        drop <= 1'b1;
      end else if (imem_rsp_valid_i_ifu) begin
        drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_reg <= NOP_INST;
      pc_o_ifu <= RESET_PC;
    end else if (redirect_valid_i_ifu) begin
      if (redirect_bad) begin
        inst_reg <= NOP_INST;
        pc_o_ifu <= redirect_pc_i_ifu;
      end
    end else if ((state == S_WAIT) && imem_rsp_valid_i_ifu && !drop) begin
      inst_reg <= imem_rsp_data_i_ifu;
      pc_o_ifu <= pc;
    end
  end

`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_o_ifu <= 1'b0;
    end else if (redirect_valid_i_ifu) begin
      excp_o_ifu <= redirect_bad;
    end else if ((state == S_HOLD) && inst_ready_i_ifu) begin
      excp_o_ifu <= 1'b0;
    end
  end
`endif

  assign imem_req_valid_o_ifu = (state == S_REQ);
  assign imem_addr_o_ifu      = pc;
  assign inst_valid_o_ifu     = (state == S_HOLD);
  assign inst_o_ifu           = inst_valid_o_ifu ? inst_reg : NOP_INST;

endmodule
